// File: rtl/id_operand_stage.sv
// Decode-stage operand front end: IF->ID register, instruction hold buffer for
// synchronous inst SRAM, priority operand forwarding and precise load-use interlock.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall_id,
  input  logic                      stall_ex,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               inst_rdata,
  input  logic                      use_rs,
  input  logic                      use_rt,
  output logic [RA_W-1:0]           rf_raddr1,
  output logic [RA_W-1:0]           rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*RA_W-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  output logic                      id_valid,
  output logic [31:0]               id_pc,
  output logic [31:0]               id_inst,
  output logic [DATA_W-1:0]         rdata1,
  output logic [DATA_W-1:0]         rdata2,
  output logic                      stallreq,
  output logic [CNT_W-1:0]          interlock_cnt
);

  logic              valid_r;
  logic [31:0]       pc_r;
  logic              hold_vld_r;
  logic [31:0]       hold_inst_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [31:0]       inst_s;
  logic [RA_W-1:0]   raddr1_s;
  logic [RA_W-1:0]   raddr2_s;
  logic [DATA_W:0]   op1_s;
  logic [DATA_W:0]   op2_s;
  logic              stallreq_s;

  // Returns {pending, data} of the winning source; scanning high to low lets channel 0 win.
  function automatic logic [DATA_W:0] resolve(
    input logic [RA_W-1:0]           addr,
    input logic [DATA_W-1:0]         rf,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD*RA_W-1:0]   wa,
    input logic [NUM_FWD*DATA_W-1:0] wd,
    input logic [NUM_FWD-1:0]        pend
  );
    logic [DATA_W:0] r;
    r = {1'b0, rf};
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      r = (we[k] && (wa[k*RA_W +: RA_W] == addr)) ? {pend[k], wd[k*DATA_W +: DATA_W]} : r;
    end
    r = (addr == {RA_W{1'b0}}) ? {1'b0, {DATA_W{1'b0}}} : r;
    return r;
  endfunction

  // IF->ID slot register with bubble insertion and one-shot hold-buffer capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      pc_r        <= 32'h0000_0000;
      hold_vld_r  <= 1'b0;
      hold_inst_r <= 32'h0000_0000;
    end else if (flush) begin
      valid_r    <= 1'b0;
      hold_vld_r <= 1'b0;
    end else if (stall_id && !stall_ex) begin
      valid_r    <= 1'b0;
      hold_vld_r <= 1'b0;
    end else if (!stall_id) begin
      valid_r    <= in_valid;
      pc_r       <= in_pc;
      hold_vld_r <= 1'b0;
    end else if (valid_r && !hold_vld_r) begin
      // SRAM output moves on after the first held cycle; freeze the word now.
      hold_inst_r <= inst_rdata;
      hold_vld_r  <= 1'b1;
    end
  end

  // Saturating interlock-cycle counter; deliberately ignores flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (stallreq_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Effective instruction selection and register-address extraction.
  always_comb begin
    inst_s = 32'h0000_0000;
    if (!valid_r) begin
      inst_s = 32'h0000_0000;
    end else if (hold_vld_r) begin
      inst_s = hold_inst_r;
    end else begin
      inst_s = inst_rdata;
    end
    raddr1_s = inst_s[21 +: RA_W];
    raddr2_s = inst_s[16 +: RA_W];
  end

  // Operand resolution and true-dependency interlock.
  always_comb begin
    op1_s      = resolve(raddr1_s, rf_rdata1, fwd_we, fwd_waddr, fwd_wdata, fwd_pending);
    op2_s      = resolve(raddr2_s, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata, fwd_pending);
    stallreq_s = valid_r & ((use_rs & op1_s[DATA_W]) | (use_rt & op2_s[DATA_W]));
  end

  assign rf_raddr1     = raddr1_s;
  assign rf_raddr2     = raddr2_s;
  assign rdata1        = op1_s[DATA_W-1:0];
  assign rdata2        = op2_s[DATA_W-1:0];
  assign stallreq      = stallreq_s;
  assign id_valid      = valid_r & ~stallreq_s & ~flush;
  assign id_pc         = pc_r;
  assign id_inst       = inst_s;
  assign interlock_cnt = cnt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding priority, load-use interlock,
// hold buffer, flush, bubble and counter saturation (CNT_W=4).
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, stall_id, stall_ex, in_valid;
  logic [31:0] in_pc, inst_rdata;
  logic        use_rs, use_rt;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_we, fwd_pending;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic        id_valid, stallreq;
  logic [31:0] id_pc, id_inst, rdata1, rdata2;
  logic [3:0]  interlock_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] ADDU_R5 = {6'd0, 5'd5, 5'd0, 5'd4, 5'd0, 6'h21};
  localparam logic [31:0] CONS_R3 = {6'd0, 5'd3, 5'd7, 5'd6, 5'd0, 6'h21};
  localparam logic [31:0] ORI_RT3 = {6'h0d, 5'd8, 5'd3, 16'h0001};
  localparam logic [31:0] WORD_A  = 32'h0123_4567;
  localparam logic [31:0] WORD_B  = 32'h0246_8ACE; // rs = r18

  id_operand_stage #(.DATA_W(32), .RA_W(5), .NUM_FWD(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .stall_ex(stall_ex),
    .in_valid(in_valid), .in_pc(in_pc), .inst_rdata(inst_rdata),
    .use_rs(use_rs), .use_rt(use_rt),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rdata1(rdata1), .rdata2(rdata2), .stallreq(stallreq), .interlock_cnt(interlock_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] addr,
                         input logic [31:0] data, input logic pend);
    fwd_we[k]             = we;
    fwd_waddr[k*5 +: 5]   = addr;
    fwd_wdata[k*32 +: 32] = data;
    fwd_pending[k]        = pend;
  endtask

  task automatic clear_fwd();
    fwd_we = 3'b000; fwd_waddr = 15'h0; fwd_wdata = 96'h0; fwd_pending = 3'b000;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; in_valid = 1'b0;
    in_pc = 32'h0; inst_rdata = 32'h0; use_rs = 1'b0; use_rt = 1'b0;
    rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
    clear_fwd();
    tick(); tick();
    check("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_stallreq", {31'h0, stallreq}, 32'h0);
    check("rst_cnt", {28'h0, interlock_cnt}, 32'h0);
    rst = 1'b0;

    // Priority forwarding
    in_valid = 1'b1; in_pc = 32'h100; tick();
    stall_id = 1'b1; stall_ex = 1'b1;
    inst_rdata = ADDU_R5; rf_rdata1 = 32'h5555; rf_rdata2 = 32'h6666;
    set_fwd(0, 1'b1, 5'd5, 32'hAAAA, 1'b0);
    set_fwd(2, 1'b1, 5'd5, 32'hBBBB, 1'b0);
    set_fwd(1, 1'b1, 5'd0, 32'h0077, 1'b0);
    #1;
    check("fwd_pc", id_pc, 32'h100);
    check("fwd_inst", id_inst, ADDU_R5);
    check("fwd_raddr1", {27'h0, rf_raddr1}, 32'd5);
    check("fwd_raddr2", {27'h0, rf_raddr2}, 32'd0);
    check("fwd_ch0_wins", rdata1, 32'hAAAA);
    check("fwd_r0_zero", rdata2, 32'h0);
    check("fwd_id_valid", {31'h0, id_valid}, 32'h1);
    set_fwd(0, 1'b0, 5'd5, 32'hAAAA, 1'b0); #1;
    check("fwd_ch2_when_ch0_off", rdata1, 32'hBBBB);
    set_fwd(2, 1'b0, 5'd5, 32'hBBBB, 1'b0); #1;
    check("fwd_rf_fallback", rdata1, 32'h5555);

    // Load-use interlock
    clear_fwd(); stall_id = 1'b0; stall_ex = 1'b0; in_pc = 32'h104; tick();
    inst_rdata = CONS_R3; use_rs = 1'b1; use_rt = 1'b1;
    set_fwd(0, 1'b1, 5'd3, 32'hDEAD, 1'b1);
    stall_id = 1'b1; stall_ex = 1'b1; #1;
    check("lu_stallreq", {31'h0, stallreq}, 32'h1);
    check("lu_id_valid", {31'h0, id_valid}, 32'h0);
    tick();
    inst_rdata = 32'hFFFF_FFFF; clear_fwd();
    set_fwd(1, 1'b1, 5'd3, 32'h1234, 1'b0);
    stall_id = 1'b0; stall_ex = 1'b0; #1;
    check("lu_release_stallreq", {31'h0, stallreq}, 32'h0);
    check("lu_release_valid", {31'h0, id_valid}, 32'h1);
    check("lu_rdata1", rdata1, 32'h1234);
    check("lu_rdata2_rf", rdata2, 32'h6666);
    check("lu_held_inst", id_inst, CONS_R3);
    check("lu_cnt", {28'h0, interlock_cnt}, 32'd1);
    set_fwd(0, 1'b1, 5'd3, 32'h0042, 1'b0);
    set_fwd(1, 1'b1, 5'd3, 32'h1234, 1'b1); #1;
    check("shadow_no_stall", {31'h0, stallreq}, 32'h0);
    check("shadow_rdata1", rdata1, 32'h42);

    // rt dependency without use_rt
    clear_fwd(); in_pc = 32'h108; tick();
    inst_rdata = ORI_RT3; use_rs = 1'b1; use_rt = 1'b0;
    set_fwd(0, 1'b1, 5'd3, 32'h0, 1'b1); #1;
    check("rt_unused_no_stall", {31'h0, stallreq}, 32'h0);
    check("rt_unused_valid", {31'h0, id_valid}, 32'h1);
    use_rt = 1'b1; #1;
    check("rt_used_stall", {31'h0, stallreq}, 32'h1);
    use_rt = 1'b0; use_rs = 1'b0; clear_fwd();

    // Hold buffer
    in_pc = 32'h10C; tick();
    inst_rdata = WORD_A; stall_id = 1'b1; stall_ex = 1'b1; #1;
    check("hold_c1", id_inst, WORD_A);
    tick(); inst_rdata = 32'hDEAD_BEEF; #1;
    check("hold_c2", id_inst, WORD_A);
    tick(); #1;
    check("hold_c3", id_inst, WORD_A);
    check("hold_pc", id_pc, 32'h10C);
    stall_id = 1'b0; stall_ex = 1'b0; in_pc = 32'h110; tick();
    inst_rdata = WORD_B; #1;
    check("hold_next_inst", id_inst, WORD_B);
    check("hold_next_pc", id_pc, 32'h110);

    // Flush during interlock
    use_rs = 1'b1; set_fwd(0, 1'b1, 5'd18, 32'h0, 1'b1);
    stall_id = 1'b1; stall_ex = 1'b1; #1;
    check("fl_stallreq", {31'h0, stallreq}, 32'h1);
    tick(); flush = 1'b1; #1;
    check("fl_same_cycle_valid", {31'h0, id_valid}, 32'h0);
    tick(); flush = 1'b0; #1;
    check("fl_after_valid", {31'h0, id_valid}, 32'h0);
    check("fl_after_stallreq", {31'h0, stallreq}, 32'h0);
    check("fl_after_inst", id_inst, 32'h0);
    check("fl_cnt", {28'h0, interlock_cnt}, 32'd3);

    // Bubble: stall_id without stall_ex
    clear_fwd(); use_rs = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; in_pc = 32'h114; tick();
    inst_rdata = 32'h1111_1111; #1;
    check("bub_pre_valid", {31'h0, id_valid}, 32'h1);
    stall_id = 1'b1; tick(); #1;
    check("bub_valid", {31'h0, id_valid}, 32'h0);
    check("bub_inst", id_inst, 32'h0);

    // Counter saturation
    stall_id = 1'b0; in_pc = 32'h118; tick();
    inst_rdata = WORD_B; use_rs = 1'b1; set_fwd(0, 1'b1, 5'd18, 32'h0, 1'b1);
    stall_id = 1'b1; stall_ex = 1'b1; #1;
    check("cnt_stallreq", {31'h0, stallreq}, 32'h1);
    repeat (11) tick();
    check("cnt_14", {28'h0, interlock_cnt}, 32'd14);
    repeat (9) tick();
    check("cnt_sat", {28'h0, interlock_cnt}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
